// File: rtl/spi_slv16.sv
// spi_slv16 -- 16-bit SPI slave (SCLK idles high, data changes on falling
// SCLK and is sampled on rising SCLK, MSB first).
//
// Ports:
//   clk      system clock, all state updates on its rising edge
//   rst_n    asynchronous active-low reset
//   SS_n     slave select from the master, active low, asynchronous to clk
//   SCLK     serial clock from the master, asynchronous to clk
//   MOSI     serial data from the master
//   MISO     serial data to the master, driven 0 while SS_n is high
//   tx_data  response word for the next frame
//   wrt      one-clk strobe that captures tx_data into the response buffer
//   cmd      last complete 16-bit word received
//   cmd_rdy  one-clk pulse coincident with an update of cmd
//   frm_err  one-clk pulse when a frame ends with a bit count other than 16
module spi_slv16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  input  logic        wrt,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizer and edge-detect flops
  logic ss_n_s1_q, ss_n_s2_q, ss_n_s3_q;
  logic ss_n_s1_d, ss_n_s2_d, ss_n_s3_d;
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sclk_s1_d, sclk_s2_d, sclk_s3_d;
  logic mosi_s1_q, mosi_s2_q;
  logic mosi_s1_d, mosi_s2_d;

  // Start-up qualification of SS_n
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  // Core state
  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] tx_buf_q, tx_buf_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        frm_err_q, frm_err_d;

  logic sclk_rise;
  logic ss_fall;
  logic ss_rise;

  // The synchronizers reset to 1, so a select that is already low when reset
  // releases would look like a falling edge. fill_q waits until all three
  // SS_n flops hold real samples, and armed_q only opens once SS_n has been
  // seen high, so such a frame is ignored until a genuine new falling edge.
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign ss_fall   = armed_q & ss_n_s3_q & ~ss_n_s2_q;
  assign ss_rise   = ss_n_s2_q & ~ss_n_s3_q;

  // MISO follows raw SS_n so the line is released immediately on deselect.
  assign MISO    = ~SS_n & shift_q[15];
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;

  always_comb begin
    ss_n_s1_d = SS_n;
    ss_n_s2_d = ss_n_s1_q;
    ss_n_s3_d = ss_n_s2_q;
    sclk_s1_d = SCLK;
    sclk_s2_d = sclk_s1_q;
    sclk_s3_d = sclk_s2_q;
    mosi_s1_d = MOSI;
    mosi_s2_d = mosi_s1_q;

    fill_d  = (fill_q == 2'd3) ? fill_q : 2'(fill_q + 2'd1);
    armed_d = armed_q | ((fill_q == 2'd3) & ss_n_s2_q);

    tx_buf_d  = wrt ? tx_data : tx_buf_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = 1'b0;
    frm_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A write landing on the same clock as the select edge is forwarded
        // straight into the shifter rather than waiting for tx_buf.
        if (ss_fall) begin
          state_d   = ACTIVE;
          shift_d   = wrt ? tx_data : tx_buf_q;
          bit_cnt_d = 5'd0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt_q == 5'd16) begin
            cmd_d     = shift_q;
            cmd_rdy_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], mosi_s2_q};
          if (bit_cnt_q != 5'd31) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_s1_q <= 1'b1;
      ss_n_s2_q <= 1'b1;
      ss_n_s3_q <= 1'b1;
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      mosi_s1_q <= 1'b1;
      mosi_s2_q <= 1'b1;
      fill_q    <= 2'd0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      shift_q   <= 16'h0000;
      tx_buf_q  <= 16'h0000;
      bit_cnt_q <= 5'd0;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      ss_n_s1_q <= ss_n_s1_d;
      ss_n_s2_q <= ss_n_s2_d;
      ss_n_s3_q <= ss_n_s3_d;
      sclk_s1_q <= sclk_s1_d;
      sclk_s2_q <= sclk_s2_d;
      sclk_s3_q <= sclk_s3_d;
      mosi_s1_q <= mosi_s1_d;
      mosi_s2_q <= mosi_s2_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      tx_buf_q  <= tx_buf_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
    end
  end

endmodule

// File: tb/tb_spi_slv16.sv
// tb_spi_slv16 -- randomized scoreboard bench for spi_slv16.
// An SPI master model drives frames at SCLK = clk/32. Each frame pushes its
// expected end-of-frame result (cmd_rdy with the sent word, or frm_err with
// cmd unchanged) into a queue; a monitor pops one entry per output pulse.
// The word returned on MISO is compared to the response buffer the bench
// tracks from its own writes.
module tb_spi_slv16;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic        wrt;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  typedef struct {
    logic        ok;
    logic [15:0] cmd;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_tx_buf;
  logic [15:0] model_cmd;
  int          checks;
  int          failures;

  spi_slv16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .cmd_rdy (cmd_rdy),
    .frm_err (frm_err)
  );

  // 10-unit system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doWrite(input logic [15:0] v);
    tx_data = v;
    wrt     = 1'b1;
    waitClks(1);
    wrt          = 1'b0;
    model_tx_buf = v;
  endtask

  // One frame of nbits SCLK cycles; an optional write is issued at bit wrt_at.
  task automatic applyStimulus(input logic [15:0] word, input int nbits,
                               input int wrt_at, input logic [15:0] wrt_val);
    logic [15:0] exp_rd;
    logic [15:0] rd;
    exp_rd = model_tx_buf;
    rd     = 16'h0000;
    SS_n   = 1'b0;
    waitClks(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == wrt_at) doWrite(wrt_val);
      SCLK = 1'b0;
      MOSI = (i < 16) ? word[15-i] : 1'($urandom);
      waitClks(16);
      SCLK = 1'b1;
      if (i < 16) rd[15-i] = MISO;
      waitClks(16);
    end
    if (nbits == 16) begin
      exp_q.push_back('{ok: 1'b1, cmd: word});
      model_cmd = word;
    end else begin
      exp_q.push_back('{ok: 1'b0, cmd: model_cmd});
    end
    SS_n = 1'b1;
    waitClks(14);
    if (nbits == 16) checkOutput("miso_word", rd, exp_rd);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (cmd_rdy || frm_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: got cmd_rdy=%b frm_err=%b expected none at %0t",
                 cmd_rdy, frm_err, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, e.ok});
        checkOutput("frm_err", {15'd0, frm_err}, {15'd0, ~e.ok});
        checkOutput("cmd", cmd, e.cmd);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    model_tx_buf = 16'h0000;
    model_cmd    = 16'h0000;
    rst_n        = 1'b0;
    SS_n         = 1'b1;
    SCLK         = 1'b1;
    MOSI         = 1'b0;
    wrt          = 1'b0;
    tx_data      = 16'h0000;

    // Reset state
    waitClks(3);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkOutput("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'h0000);
    checkOutput("rst_frm_err", {15'd0, frm_err}, 16'h0000);
    checkOutput("rst_miso", {15'd0, MISO}, 16'h0000);
    rst_n = 1'b1;
    waitClks(6);

    // Load and send
    doWrite(16'hA5C3);
    waitClks(2);
    applyStimulus(16'h1234, 16, -1, 16'h0000);

    // Mid-frame buffer update, then back-to-back frames
    doWrite(16'h0F0F);
    applyStimulus(16'($urandom), 16, 8, 16'hFFFF);
    applyStimulus(16'($urandom), 16, -1, 16'h0000);

    // Short, long and empty frames
    applyStimulus(16'($urandom), 9, -1, 16'h0000);
    applyStimulus(16'($urandom), 17, -1, 16'h0000);
    applyStimulus(16'($urandom), 0, -1, 16'h0000);

    // Reset in the middle of a frame, released while SS_n is still low
    doWrite(16'h5A5A);
    SS_n = 1'b0;
    waitClks(6);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0;
      MOSI = 1'($urandom);
      waitClks(16);
      SCLK = 1'b1;
      waitClks(16);
    end
    rst_n        = 1'b0;
    model_tx_buf = 16'h0000;
    model_cmd    = 16'h0000;
    waitClks(2);
    checkOutput("midrst_cmd", cmd, 16'h0000);
    checkOutput("midrst_cmd_rdy", {15'd0, cmd_rdy}, 16'h0000);
    checkOutput("midrst_frm_err", {15'd0, frm_err}, 16'h0000);
    checkOutput("midrst_miso", {15'd0, MISO}, 16'h0000);
    rst_n = 1'b1;
    waitClks(10);
    SS_n = 1'b1;
    waitClks(20);
    applyStimulus(16'hBEEF, 16, -1, 16'h0000);

    // Random traffic
    for (int n = 0; n < 100; n++) begin
      int nbits;
      int wat;
      if ($urandom_range(0, 1) == 1) doWrite(16'($urandom));
      nbits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : 16;
      wat   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : -1;
      applyStimulus(16'($urandom), nbits, wat, 16'($urandom));
    end

    waitClks(10);
    checkOutput("pending_expectations", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slv16.md
SPI_SLV16 -- requirements
Module: spi_slv16

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  system clock; all state is updated on the rising edge of clk.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 SS_n  input  1  SPI slave select, active low, asynchronous to clk.
REQ-005 SCLK  input  1  SPI serial clock, idles high, asynchronous to clk; its period SHALL be at least 16 clk.
REQ-006 MOSI  input  1  master-to-slave serial data, MSB first.
REQ-007 MISO  output  1  slave-to-master serial data, MSB first.
REQ-008 tx_data  input  16  response word for the next frame.
REQ-009 wrt  input  1  single-clk strobe that captures tx_data.
REQ-010 cmd  output  16  last complete received word.
REQ-011 cmd_rdy  output  1  one-clk pulse: cmd has been updated.
REQ-012 frm_err  output  1  one-clk pulse: frame ended with a bit count other than 16.

Function
REQ-013 SS_n, SCLK and MOSI SHALL each pass through a two-flop synchronizer (reset value 1) before use.
REQ-014 A third flop on synced SCLK and on synced SS_n SHALL generate single-clk edge pulses: sclk_rise, ss_fall, ss_rise.
REQ-015 The state machine SHALL have two states, IDLE and ACTIVE; the reset state is IDLE.
REQ-016 IDLE -> ACTIVE on ss_fall; ACTIVE -> IDLE on ss_rise; no other transitions.
REQ-017 On ss_fall, the 16-bit shift register SHALL load tx_buf and the 5-bit bit counter SHALL clear to 0.
REQ-018 In ACTIVE on sclk_rise, the shift register SHALL shift left with the synced MOSI entering bit 0, and the bit counter SHALL increment, saturating at 31.
REQ-019 MISO SHALL equal shift-register bit 15 while raw SS_n is low, and 0 while SS_n is high.
REQ-020 A shift triggered by an SCLK rise SHALL be visible on MISO within 3 clk of that rise, so the master always samples the pre-shift bit.
REQ-021 On ss_rise with bit counter == 16: cmd <= shift register, and cmd_rdy pulses for 1 clk in the same cycle that cmd updates.
REQ-022 On ss_rise with bit counter != 16 (including 0 or more than 16): cmd holds its value, cmd_rdy stays 0, and frm_err pulses for 1 clk.
REQ-023 On wrt, tx_buf <= tx_data in any state.
REQ-024 A wrt during ACTIVE SHALL NOT affect the frame in progress; the new value is used from the next ss_fall.
REQ-025 A wrt in the same clk as ss_fall SHALL load the new tx_data directly into the shift register.
REQ-026 tx_buf SHALL persist across frames until the next wrt.
REQ-027 SCLK edges while in IDLE SHALL be ignored.
REQ-028 Synced MOSI SHALL be used unmodified; there is no parity or length field.

Reset
REQ-029 While rst_n is low: state = IDLE, shift register = 0, tx_buf = 0, bit counter = 0, cmd = 0x0000, cmd_rdy = 0, frm_err = 0, and all synchronizer flops = 1.
REQ-030 Reset assertion mid-frame SHALL abort the frame with no cmd_rdy and no frm_err.
REQ-031 After reset deasserts, if SS_n is still low, the block SHALL stay IDLE until a fresh ss_fall.

Verification
REQ-032 Load and send: wrt with tx_data=0xA5C3, master sends 0x1234 -> MISO shifts out 0xA5C3, cmd=0x1234, exactly one cmd_rdy pulse, frm_err=0.
REQ-033 Mid-frame update: wrt 0x0F0F, then wrt 0xFFFF at bit 8, two back-to-back frames -> frame 1 returns 0x0F0F, frame 2 returns 0xFFFF.
REQ-034 Short frame: 9 SCLK cycles, then SS_n high -> frm_err pulses once, cmd unchanged, no cmd_rdy.
REQ-035 Long frame: 17 SCLK cycles -> frm_err pulses once, no cmd_rdy.
REQ-036 Mid-frame reset: rst_n low at bit 5, a new full frame with 0xBEEF after reset -> after reset all outputs are 0, then cmd=0xBEEF and MISO returns 0x0000.
REQ-037 Loopback: drive this block with SPI_mstr16 at SCLK = clk/32 for 100 random words -> every rd_data equals the preloaded tx_data, and every cmd equals the master's cmd.
